shift_unit: RTL and testbench

- Registered shift stage of the ALU datapath.
- Each cycle it selects operand a or b, shifts it one bit left or right (logical), and registers the result.
- It also registers a valid flag, shift_flag.
- The ALU top enables this unit when a shift opcode is decoded. Outputs return to zero when the unit is disabled.

---
 rtl/shift_unit.sv | 49 ++++
 tb/tb_shift_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Registered one-bit logical shift stage: selects operand a or b, shifts it
// left or right by one, and registers the result with a valid flag.
module shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       func,
    input  logic             enable,
    output logic [WIDTH-1:0] shift_out,
    output logic             shift_flag
);

    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] shift_out_d;
    logic [WIDTH-1:0] shift_out_q;
    logic             shift_flag_d;
    logic             shift_flag_q;

    // func[1] picks the operand, func[0] picks the direction (1 = left).
    always_comb begin
        operand      = func[1] ? b : a;
        shifted      = func[0] ? {operand[WIDTH-2:0], 1'b0}
                               : {1'b0, operand[WIDTH-1:1]};
        shift_out_d  = '0;
        shift_flag_d = 1'b0;
        if (enable) begin
            shift_out_d  = shifted;
            shift_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_out_q  <= '0;
            shift_flag_q <= 1'b0;
        end else begin
            shift_out_q  <= shift_out_d;
            shift_flag_q <= shift_flag_d;
        end
    end

    assign shift_out  = shift_out_q;
    assign shift_flag = shift_flag_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit: vector table plus hand-written
// reset, disable and asynchronous-reset sequences.
module tb_shift_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       func;
    logic             enable;
    logic [WIDTH-1:0] shift_out;
    logic             shift_flag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  func;
        logic        en;
        logic [15:0] exp_out;
        logic        exp_flag;
    } vec_t;

    vec_t vecs [12];

    shift_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .func       (func),
        .enable     (enable),
        .shift_out  (shift_out),
        .shift_flag (shift_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Reference written arithmetically, independent of the RTL's bit slicing.
    function automatic logic [15:0] ref_shift(input logic [15:0] ra, input logic [15:0] rb,
                                              input logic [1:0] rf);
        int unsigned x;
        x = rf[1] ? int'(rb) : int'(ra);
        if (rf[0]) ref_shift = 16'((x * 2) % 65536);
        else       ref_shift = 16'(x / 2);
    endfunction

    initial begin
        logic [15:0] ra, rb, exp_o;
        logic [1:0]  rf;

        vecs[0]  = '{16'h8001, 16'h0000, 2'b00, 1'b1, 16'h4000, 1'b1};
        vecs[1]  = '{16'h8001, 16'h0000, 2'b01, 1'b1, 16'h0002, 1'b1};
        vecs[2]  = '{16'h1234, 16'hFFFF, 2'b10, 1'b1, 16'h7FFF, 1'b1};
        vecs[3]  = '{16'h0000, 16'hFFFF, 2'b11, 1'b1, 16'hFFFE, 1'b1};
        vecs[4]  = '{16'h0001, 16'hFFFF, 2'b00, 1'b1, 16'h0000, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'h0000, 2'b01, 1'b1, 16'hFFFE, 1'b1};
        vecs[6]  = '{16'hFFFF, 16'h0001, 2'b10, 1'b1, 16'h0000, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'h8000, 2'b11, 1'b1, 16'h0000, 1'b1};
        vecs[8]  = '{16'h0000, 16'h5555, 2'b11, 1'b1, 16'hAAAA, 1'b1};
        vecs[9]  = '{16'hAAAA, 16'h0000, 2'b00, 1'b1, 16'h5555, 1'b1};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 2'b01, 1'b0, 16'h0000, 1'b0};
        vecs[11] = '{16'h0000, 16'h1234, 2'b10, 1'b1, 16'h091A, 1'b1};

        rst = 1'b0; enable = 1'b1; a = '0; b = '0; func = 2'b00;

        // Reset held low: outputs stay zero whatever the inputs do.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_out", 32'(shift_out), 32'h0);
            check("reset_flag", 32'(shift_flag), 32'h0);
            a = 16'($urandom); b = 16'($urandom); func = 2'($urandom); enable = 1'($urandom);
        end

        // Release between edges; the first edge after release loads a result.
        enable = 1'b1; a = 16'h8001; func = 2'b00;
        #2 rst = 1'b1;
        @(negedge clk);
        check("release_first_edge", 32'(shift_out), 32'h4000);

        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a; b = vecs[i].b; func = vecs[i].func; enable = vecs[i].en;
            @(negedge clk);
            check($sformatf("vec%0d_out", i), 32'(shift_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_flag", i), 32'(shift_flag), 32'(vecs[i].exp_flag));
        end

        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rf = 2'($urandom);
            a = ra; b = rb; func = rf;
            exp_o = ref_shift(ra, rb, rf);
            @(negedge clk);
            check($sformatf("rand%0d_f%0d_out", i, rf), 32'(shift_out), 32'(exp_o));
            check("rand_flag", 32'(shift_flag), 32'h1);
        end

        // Disable after a valid result.
        a = 16'h8001; func = 2'b00; enable = 1'b1;
        @(negedge clk);
        check("pre_disable_out", 32'(shift_out), 32'h4000);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom); func = 2'($urandom);
            @(negedge clk);
            check("disabled_out", 32'(shift_out), 32'h0);
            check("disabled_flag", 32'(shift_flag), 32'h0);
        end

        // Asynchronous reset pulse between edges.
        enable = 1'b1; b = 16'h5555; func = 2'b11;
        @(negedge clk);
        check("pre_async_out", 32'(shift_out), 32'hAAAA);
        #1 rst = 1'b0;
        #1;
        check("async_out", 32'(shift_out), 32'h0);
        check("async_flag", 32'(shift_flag), 32'h0);
        #1 rst = 1'b1;
        a = 16'h0003; func = 2'b01;
        @(negedge clk);
        check("post_async_out", 32'(shift_out), 32'h0006);
        check("post_async_flag", 32'(shift_flag), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
